// File: rtl/md_scheduler_if.sv
// Handshake bundle between the E/D pipeline stages and the multiply/divide
// sequencer. The pipeline side is the master; the sequencer is the slave.
interface md_scheduler_if;
    logic        e_start;
    logic [2:0]  e_op;
    logic [31:0] e_rs_val;
    logic [31:0] e_rt_val;
    logic        d_md_use;
    logic        busy;
    logic        md_stall;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output e_start, e_op, e_rs_val, e_rt_val, d_md_use,
        input  busy, md_stall, done, hi, lo
    );

    modport slave (
        input  e_start, e_op, e_rs_val, e_rt_val, d_md_use,
        output busy, md_stall, done, hi, lo
    );
endinterface

// File: rtl/md_scheduler.sv
// Multi-cycle multiply/divide sequencer for the 5-stage MIPS pipeline.
// Owns HI/LO. The 64-bit result is computed in the issue cycle and held in
// pend_hi/pend_lo; a down-counter models the architectural latency before
// the result is committed to HI/LO.
module md_scheduler #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic           clk,
    input  logic           reset,
    md_scheduler_if.slave  md
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

    // Two's-complement negation of a 32-bit value.
    function automatic logic [31:0] neg32(input logic [31:0] v);
        return (~v) + 32'd1;
    endfunction

    logic [0:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] pend_hi_q, pend_hi_d;
    logic [31:0] pend_lo_q, pend_lo_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;

    logic        is_signed;
    logic [63:0] a_ext, b_ext, prod;
    logic [31:0] abs_a, abs_b, div_b, uq, ur, quot, rem;
    logic        neg_q, neg_r;
    logic [31:0] res_hi, res_lo;
    logic        is_md_op;

    // Combinational 64-bit result for the operation presented in E.
    // One shared multiplier: the low 64 bits of the product of sign- or
    // zero-extended operands give both the signed and unsigned result.
    // Signed divide runs on magnitudes so the INT_MIN / -1 case falls out
    // naturally as quotient 0x80000000, remainder 0.
    always_comb begin
        is_signed = ~md.e_op[0];
        a_ext     = {{32{is_signed & md.e_rs_val[31]}}, md.e_rs_val};
        b_ext     = {{32{is_signed & md.e_rt_val[31]}}, md.e_rt_val};
        prod      = a_ext * b_ext;

        abs_a = (is_signed & md.e_rs_val[31]) ? neg32(md.e_rs_val) : md.e_rs_val;
        abs_b = (is_signed & md.e_rt_val[31]) ? neg32(md.e_rt_val) : md.e_rt_val;
        div_b = (abs_b == 32'd0) ? 32'd1 : abs_b;
        uq    = abs_a / div_b;
        ur    = abs_a % div_b;
        neg_q = is_signed & (md.e_rs_val[31] ^ md.e_rt_val[31]);
        neg_r = is_signed & md.e_rs_val[31];
        quot  = neg_q ? neg32(uq) : uq;
        rem   = neg_r ? neg32(ur) : ur;

        if (md.e_op[1]) begin
            if (md.e_rt_val == 32'd0) begin
                res_hi = md.e_rs_val;
                res_lo = 32'hFFFF_FFFF;
            end else begin
                res_hi = rem;
                res_lo = quot;
            end
        end else begin
            res_hi = prod[63:32];
            res_lo = prod[31:0];
        end
    end

    // Next-state logic for the IDLE/BUSY sequencer and HI/LO writes.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (md.e_start) begin
                    case (md.e_op)
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            pend_hi_d = res_hi;
                            pend_lo_d = res_lo;
                            cnt_d     = md.e_op[1] ? DIV_CNT : MULT_CNT;
                            state_d   = S_BUSY;
                        end
                        OP_MTHI: hi_d = md.e_rs_val;
                        OP_MTLO: lo_d = md.e_rs_val;
                        default: ;
                    endcase
                end
            end
            S_BUSY: begin
                // New issues are ignored here; md_stall keeps them out.
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    hi_d    = pend_hi_q;
                    lo_d    = pend_lo_q;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset discards any in-flight result and clears HI/LO.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign is_md_op    = md.e_start & ~md.e_op[2];
    assign md.busy     = (state_q == S_BUSY);
    assign md.md_stall = md.d_md_use & ((state_q == S_BUSY) | is_md_op);
    assign md.done     = done_q;
    assign md.hi       = hi_q;
    assign md.lo       = lo_q;

endmodule

// File: doc/md_scheduler.md
Name: md_scheduler

Overview:
- Multi-cycle multiply/divide unit sequencer for the 5-stage MIPS pipeline.
- Accepts mult/multu/div/divu/mthi/mtlo issued from the E stage and owns the HI/LO registers.
- Models fixed multi-cycle latency with a busy counter.
- Drives a stall request that the pipeline hazard logic ORs into its freeze of the F/D and D/E registers whenever a D-stage HI/LO-using instruction would hit a busy unit.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15)
DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
e_start  in  1  E-stage instruction is an MD op this cycle
e_op  in  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo; 110/111 reserved
e_rs_val  in  32  forwarded rs operand
e_rt_val  in  32  forwarded rt operand
d_md_use  in  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
busy  out  1  multi-cycle operation in progress
md_stall  out  1  stall request to the hazard unit
done  out  1  one-cycle pulse when HI/LO written by mult/div
hi  out  32  HI register
lo  out  32  LO register

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, counter 0, busy 0, done 0, hi 0, lo 0, pending result regs 0.
- States: IDLE, BUSY. 4-bit down-counter cnt.
- IDLE, e_start=1, e_op mult/multu/div/divu, sampled at edge T:
  - compute the 64-bit result combinationally from e_rs_val and e_rt_val;
  - latch it into pend_hi/pend_lo;
  - set cnt = MULT_CYCLES or DIV_CYCLES;
  - go to BUSY.
- BUSY: busy=1. cnt decrements each edge. On the edge where cnt==1: hi<=pend_hi, lo<=pend_lo, done=1 for the following cycle, state to IDLE.
- Latency: start sampled at edge T. busy is high for exactly N cycles after T. New hi/lo are visible after edge T+N, the same cycle done=1.
- IDLE, e_start=1, mthi: hi<=e_rs_val at the next edge, no busy, no done. mtlo: lo<=e_rs_val likewise.
- e_start in BUSY: ignored, with no effect on state, counter, pend or hi/lo. This cannot legally occur because md_stall prevents it.
- Reserved e_op with e_start=1: ignored.
- mult: signed 32x32->64; hi=upper 32 bits, lo=lower 32 bits. multu: unsigned.
- div: lo=signed quotient truncated toward zero; hi=remainder with the sign of the dividend. divu: unsigned.
- Divide by zero (e_rt_val==0): lo=32'hFFFFFFFF, hi=e_rs_val. Applies to both div and divu.
- Signed overflow (div 32'h80000000 / 32'hFFFFFFFF): lo=32'h80000000, hi=0.
- md_stall = d_md_use & (busy | (e_start & e_op is mult/multu/div/divu)). Purely combinational.
- md_stall deasserts in the cycle done=1, so mfhi/mflo in D reads the new hi/lo through normal E-stage use.
- hi/lo are registered outputs. A reader in the same cycle as an mthi/mtlo edge sees the old value; the pipeline forwards as needed.
- Reset asserted mid-BUSY: immediate return to IDLE, pending result discarded, hi/lo cleared to 0, busy and md_stall low.

Test Plan:
1. Reset released, idle: busy=0, md_stall=0, hi=lo=0. Then e_start, mult, rs=32'hFFFFFFFE (-2), rt=3 -> busy high for 5 cycles, then hi=32'hFFFFFFFF, lo=32'hFFFFFFFA, done pulse of exactly 1 cycle.
2. multu rs=rt=32'hFFFFFFFF -> after 5 busy cycles hi=32'hFFFFFFFE, lo=32'h00000001.
3. div rs=-7 (32'hFFFFFFF9), rt=2 -> 10 busy cycles, then lo=32'hFFFFFFFD (-3), hi=32'hFFFFFFFF (-1). divu rs=7, rt=0 -> lo=32'hFFFFFFFF, hi=7. div 32'h80000000 / 32'hFFFFFFFF -> lo=32'h80000000, hi=0.
4. mthi rs=32'h12345678, then mtlo rs=32'hCAFEBABE on the next cycle -> hi and lo update one edge after each; busy and done stay 0.
5. Start div, then hold d_md_use=1 -> md_stall=1 in the start cycle and all 10 busy cycles, 0 in the done cycle. Assert e_start with mult during BUSY -> ignored, and hi/lo end up holding the div result.
6. Start mult, pull reset low asynchronously mid-clock on busy cycle 3 -> busy, hi and lo drop to 0 immediately without a clock edge. After release, state is IDLE and done never pulses.
